// File: rtl/axis_frame_buffer_writer_if.sv
// rtl/axis_frame_buffer_writer_if.sv - N_REQ stream sources feeding the frame buffer writer
interface axis_frame_buffer_writer_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 512
) ();
  logic [N_REQ-1:0]        s_tvalid_i;
  logic [N_REQ-1:0]        s_tready_o;
  logic [N_REQ*DATA_W-1:0] s_tdata_i;
  logic [N_REQ-1:0]        s_tlast_i;

  modport master (
    output s_tvalid_i,
    output s_tdata_i,
    output s_tlast_i,
    input  s_tready_o
  );

  modport slave (
    input  s_tvalid_i,
    input  s_tdata_i,
    input  s_tlast_i,
    output s_tready_o
  );
endinterface

// File: rtl/axis_frame_buffer_writer.sv
// rtl/axis_frame_buffer_writer.sv - round-robin frame writer for the length-prefixed frame buffer
module axis_frame_buffer_writer #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 512,
  parameter int EN_W        = DATA_W / 8,
  parameter int ADDR_W      = 10,
  parameter int MAX_FRAME_W = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  axis_frame_buffer_writer_if.slave s,
  input  logic [ADDR_W-1:0]     rd_ptr_i,
  output logic [ADDR_W-1:0]     wr_ptr_o,
  output logic                  en_a_o,
  output logic [EN_W-1:0]       wren_a_o,
  output logic [ADDR_W-1:0]     wraddr_a_o,
  output logic [DATA_W-1:0]     wrdata_a_o,
  output logic [N_REQ-1:0]      grant_o,
  output logic                  busy_o,
  output logic                  err_oversize_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_DRAIN,
    ST_HDR,
    ST_PUB
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   hdr_addr_q, hdr_addr_d;
  logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic                en_a_q, en_a_d;
  logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
  logic [DATA_W-1:0]   wrdata_q, wrdata_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   used;
  logic [ADDR_W-1:0]   free_words;
  logic                eligible;
  logic                found;
  logic [IDX_W-1:0]    pick;
  logic [IDX_W:0]      cand;
  logic                sel_valid;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;

  // 2^ADDR_W - 1 - used is simply the bitwise complement of used
  assign used       = wr_ptr_q - rd_ptr_i;
  assign free_words = ~used;
  assign eligible   = ({1'b0, free_words} >= (ADDR_W+1)'(MAX_FRAME_W + 1));

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!found && s.s_tvalid_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gidx_q == IDX_W'(k)) begin
        sel_valid = s.s_tvalid_i[k];
        sel_last  = s.s_tlast_i[k];
        sel_data  = s.s_tdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    hdr_addr_d  = hdr_addr_q;
    data_addr_d = data_addr_q;
    len_d       = len_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_d        = rr_q;
    en_a_d      = 1'b0;
    wraddr_d    = wraddr_q;
    wrdata_d    = wrdata_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (eligible && found) begin
          grant_d     = N_REQ'(1) << pick;
          gidx_d      = pick;
          hdr_addr_d  = wr_ptr_q;
          data_addr_d = wr_ptr_q + ADDR_W'(1);
          len_d       = '0;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (sel_valid) begin
          en_a_d      = 1'b1;
          wraddr_d    = data_addr_q;
          wrdata_d    = sel_data;
          data_addr_d = data_addr_q + ADDR_W'(1);
          len_d       = len_q + ADDR_W'(1);
          if (sel_last) begin
            state_d = ST_HDR;
          end else if (len_q == ADDR_W'(MAX_FRAME_W - 1)) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Overflow beats are swallowed until the source closes its frame
        if (sel_valid && sel_last) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        en_a_d   = 1'b1;
        wraddr_d = hdr_addr_q;
        wrdata_d = DATA_W'(len_q);
        state_d  = ST_PUB;
      end
      ST_PUB: begin
        // Pointer moves only after the header write has been issued
        wr_ptr_d = hdr_addr_q + len_q + ADDR_W'(1);
        rr_d     = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
        grant_d  = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      hdr_addr_q  <= '0;
      data_addr_q <= '0;
      len_q       <= '0;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_q        <= '0;
      en_a_q      <= 1'b0;
      wraddr_q    <= '0;
      wrdata_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      hdr_addr_q  <= hdr_addr_d;
      data_addr_q <= data_addr_d;
      len_q       <= len_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_q        <= rr_d;
      en_a_q      <= en_a_d;
      wraddr_q    <= wraddr_d;
      wrdata_q    <= wrdata_d;
      err_q       <= err_d;
    end
  end

  assign s.s_tready_o   = ((state_q == ST_DATA) || (state_q == ST_DRAIN)) ? grant_q : '0;
  assign wr_ptr_o       = wr_ptr_q;
  assign en_a_o         = en_a_q;
  assign wren_a_o       = {EN_W{en_a_q}};
  assign wraddr_a_o     = wraddr_q;
  assign wrdata_a_o     = wrdata_q;
  assign grant_o        = grant_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign err_oversize_o = err_q;

endmodule

// File: tb/tb_axis_frame_buffer_writer.sv
// tb/tb_axis_frame_buffer_writer.sv - directed self-checking bench for axis_frame_buffer_writer
module tb_axis_frame_buffer_writer;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 512;
  localparam int EN_W   = DATA_W / 8;
  localparam int ADDR_W = 10;

  logic clk;
  logic resetn;
  logic [ADDR_W-1:0] rd_ptr_i;
  logic [ADDR_W-1:0] wr_ptr_o;
  logic              en_a_o;
  logic [EN_W-1:0]   wren_a_o;
  logic [ADDR_W-1:0] wraddr_a_o;
  logic [DATA_W-1:0] wrdata_a_o;
  logic [N_REQ-1:0]  grant_o;
  logic              busy_o;
  logic              err_oversize_o;

  axis_frame_buffer_writer_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) s_if ();

  axis_frame_buffer_writer #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .EN_W(EN_W), .ADDR_W(ADDR_W), .MAX_FRAME_W(64)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .s(s_if),
    .rd_ptr_i(rd_ptr_i),
    .wr_ptr_o(wr_ptr_o),
    .en_a_o(en_a_o),
    .wren_a_o(wren_a_o),
    .wraddr_a_o(wraddr_a_o),
    .wrdata_a_o(wrdata_a_o),
    .grant_o(grant_o),
    .busy_o(busy_o),
    .err_oversize_o(err_oversize_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          log_addr[$];
  logic [DATA_W-1:0] log_data[$];
  int          glog[$];
  int          err_cnt = 0;
  int          wren_bad = 0;
  logic [N_REQ-1:0] grant_prev = '0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mkdata(input int r, input int b);
    logic [DATA_W-1:0] d;
    d = '0;
    d[DATA_W-1 -: 8] = 8'(8'hA0 + r);
    d[31:0] = 32'(r * 65536 + b);
    return d;
  endfunction

  always @(negedge clk) begin
    if (en_a_o) begin
      log_addr.push_back(int'(wraddr_a_o));
      log_data.push_back(wrdata_a_o);
    end
    if (err_oversize_o) err_cnt++;
    if ((en_a_o && wren_a_o != {EN_W{1'b1}}) || (!en_a_o && wren_a_o != '0)) wren_bad++;
    if (grant_o != '0 && grant_prev == '0) glog.push_back(int'(grant_o));
    grant_prev = grant_o;
  end

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    glog.delete();
    err_cnt = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    s_if.s_tvalid_i = '0;
    s_if.s_tlast_i  = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    clear_logs();
  endtask

  task automatic send_frame(input int r, input int n, output int stalls);
    int w;
    stalls = 0;
    for (int b = 0; b < n; b++) begin
      s_if.s_tvalid_i[r] = 1'b1;
      s_if.s_tdata_i[r*DATA_W +: DATA_W] = mkdata(r, b);
      s_if.s_tlast_i[r] = (b == n - 1);
      w = 0;
      while (!s_if.s_tready_o[r] && w < 200) begin
        @(negedge clk);
        w++;
        stalls++;
      end
      if (w >= 200) begin
        check($sformatf("ready_timeout_r%0d", r), 0, 1);
        break;
      end
      @(negedge clk);
    end
    s_if.s_tvalid_i[r] = 1'b0;
    s_if.s_tlast_i[r]  = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy_o && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) check("idle_timeout", 0, 1);
  endtask

  task automatic fill_to(input int target);
    int gap, n, st, iter;
    iter = 0;
    while (int'(wr_ptr_o) != target && iter < 40) begin
      rd_ptr_i = wr_ptr_o;
      gap = (target - int'(wr_ptr_o)) & 1023;
      n = gap - 1;
      if (n > 64) n = 64;
      if (gap - (n + 1) == 1) n = n - 1;
      send_frame(3, n, st);
      wait_idle();
      iter++;
    end
    check("fill_target", DATA_W'(wr_ptr_o), DATA_W'(target));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st;
    resetn   = 1'b0;
    rd_ptr_i = '0;
    s_if.s_tvalid_i = '0;
    s_if.s_tdata_i  = '0;
    s_if.s_tlast_i  = '0;
    repeat (2) @(negedge clk);
    check("rst_wr_ptr", DATA_W'(wr_ptr_o), 0);
    check("rst_grant", DATA_W'(grant_o), 0);
    check("rst_en", DATA_W'({en_a_o, busy_o, err_oversize_o}), 0);
    check("rst_tready", DATA_W'(s_if.s_tready_o), 0);
    check("rst_wraddr", DATA_W'(wraddr_a_o), 0);
    check("rst_wrdata", wrdata_a_o, 0);
    resetn = 1'b1;
    clear_logs();

    // single 3-word frame from requester 0
    send_frame(0, 3, st);
    wait_idle();
    check("t1_nwrites", DATA_W'(log_addr.size()), 4);
    if (log_addr.size() == 4) begin
      check("t1_a0", DATA_W'(log_addr[0]), 1);
      check("t1_d0", log_data[0], mkdata(0, 0));
      check("t1_a1", DATA_W'(log_addr[1]), 2);
      check("t1_d1", log_data[1], mkdata(0, 1));
      check("t1_a2", DATA_W'(log_addr[2]), 3);
      check("t1_d2", log_data[2], mkdata(0, 2));
      check("t1_hdr_addr", DATA_W'(log_addr[3]), 0);
      check("t1_hdr_len", log_data[3], 3);
    end
    check("t1_wr_ptr", DATA_W'(wr_ptr_o), 4);
    check("t1_ngrant", DATA_W'(glog.size()), 1);
    if (glog.size() == 1) check("t1_grant", DATA_W'(glog[0]), 1);

    // round robin across four simultaneous single-word requesters
    do_reset();
    fork
      begin int s0; send_frame(0, 1, s0); end
      begin int s1; send_frame(1, 1, s1); end
      begin int s2; send_frame(2, 1, s2); end
      begin int s3; send_frame(3, 1, s3); end
    join
    wait_idle();
    check("t2_wr_ptr", DATA_W'(wr_ptr_o), 8);
    fork
      begin int s0; send_frame(0, 1, s0); end
      begin int s1; send_frame(1, 1, s1); end
    join
    wait_idle();
    check("t2_ngrants", DATA_W'(glog.size()), 6);
    if (glog.size() == 6) begin
      check("t2_g0", DATA_W'(glog[0]), 1);
      check("t2_g1", DATA_W'(glog[1]), 2);
      check("t2_g2", DATA_W'(glog[2]), 4);
      check("t2_g3", DATA_W'(glog[3]), 8);
      check("t2_g4_wrap", DATA_W'(glog[4]), 1);
      check("t2_g5", DATA_W'(glog[5]), 2);
    end
    check("t2_wr_ptr_end", DATA_W'(wr_ptr_o), 12);

    // space gating: free=63 blocks, free=65 grants
    do_reset();
    fill_to(960);
    rd_ptr_i = '0;
    s_if.s_tvalid_i[1] = 1'b1;
    s_if.s_tdata_i[1*DATA_W +: DATA_W] = mkdata(1, 0);
    s_if.s_tlast_i[1] = 1'b1;
    repeat (5) @(negedge clk);
    check("t3_blocked_grant", DATA_W'(grant_o), 0);
    check("t3_blocked_ready", DATA_W'(s_if.s_tready_o), 0);
    rd_ptr_i = 10'd2;
    @(negedge clk);
    check("t3_grant", DATA_W'(grant_o), 2);
    check("t3_ready", DATA_W'(s_if.s_tready_o), 2);
    @(negedge clk);
    s_if.s_tvalid_i[1] = 1'b0;
    s_if.s_tlast_i[1]  = 1'b0;
    wait_idle();
    check("t3_wr_ptr", DATA_W'(wr_ptr_o), 962);

    // 70-word frame truncated to 64, remainder drained, wraps past 1023
    rd_ptr_i = 10'd962;
    clear_logs();
    send_frame(2, 70, st);
    check("t4_stalls", DATA_W'(st), 1);
    wait_idle();
    check("t4_err_pulses", DATA_W'(err_cnt), 1);
    check("t4_nwrites", DATA_W'(log_addr.size()), 65);
    if (log_addr.size() == 65) begin
      check("t4_first_addr", DATA_W'(log_addr[0]), 963);
      check("t4_first_data", log_data[0], mkdata(2, 0));
      check("t4_addr60", DATA_W'(log_addr[60]), 1023);
      check("t4_addr61_wrap", DATA_W'(log_addr[61]), 0);
      check("t4_last_addr", DATA_W'(log_addr[63]), 2);
      check("t4_last_data", log_data[63], mkdata(2, 63));
      check("t4_hdr_addr", DATA_W'(log_addr[64]), 962);
      check("t4_hdr_len", log_data[64], 64);
    end
    check("t4_wr_ptr", DATA_W'(wr_ptr_o), 3);

    // header at 1022 with data wrapping to address 0
    do_reset();
    fill_to(1022);
    rd_ptr_i = 10'd1000;
    clear_logs();
    send_frame(0, 4, st);
    wait_idle();
    check("t5_nwrites", DATA_W'(log_addr.size()), 5);
    if (log_addr.size() == 5) begin
      check("t5_a0", DATA_W'(log_addr[0]), 1023);
      check("t5_a1", DATA_W'(log_addr[1]), 0);
      check("t5_a3", DATA_W'(log_addr[3]), 2);
      check("t5_d3", log_data[3], mkdata(0, 3));
      check("t5_hdr_addr", DATA_W'(log_addr[4]), 1022);
      check("t5_hdr_len", log_data[4], 4);
    end
    check("t5_wr_ptr", DATA_W'(wr_ptr_o), 3);

    // reset after two beats of a five-word frame
    clear_logs();
    s_if.s_tvalid_i[1] = 1'b1;
    s_if.s_tlast_i[1]  = 1'b0;
    s_if.s_tdata_i[1*DATA_W +: DATA_W] = mkdata(1, 0);
    @(negedge clk);
    check("t6_ready", DATA_W'(s_if.s_tready_o), 2);
    @(negedge clk);
    s_if.s_tdata_i[1*DATA_W +: DATA_W] = mkdata(1, 1);
    @(negedge clk);
    resetn = 1'b0;
    s_if.s_tvalid_i[1] = 1'b0;
    @(negedge clk);
    check("t6_rst_wr_ptr", DATA_W'(wr_ptr_o), 0);
    check("t6_rst_grant", DATA_W'(grant_o), 0);
    check("t6_rst_flags", DATA_W'({en_a_o, busy_o, err_oversize_o}), 0);
    check("t6_rst_ready", DATA_W'(s_if.s_tready_o), 0);
    check("t6_rst_wraddr", DATA_W'(wraddr_a_o), 0);
    resetn = 1'b1;
    check("t6_nwrites", DATA_W'(log_addr.size()), 2);
    if (log_addr.size() == 2) begin
      check("t6_a0", DATA_W'(log_addr[0]), 4);
      check("t6_a1", DATA_W'(log_addr[1]), 5);
    end
    rd_ptr_i = '0;
    clear_logs();
    send_frame(1, 1, st);
    wait_idle();
    check("t6_post_nwrites", DATA_W'(log_addr.size()), 2);
    if (log_addr.size() == 2) begin
      check("t6_post_data_addr", DATA_W'(log_addr[0]), 1);
      check("t6_post_hdr_addr", DATA_W'(log_addr[1]), 0);
      check("t6_post_hdr_len", log_data[1], 1);
    end
    check("t6_post_wr_ptr", DATA_W'(wr_ptr_o), 2);

    check("wren_consistency", DATA_W'(wren_bad), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_buffer_writer.md
Name: axis_frame_buffer_writer

Overview:
- Write-side scheduler for the length-prefixed frame buffer whose read side is the AXI-stream egress convertor.
- Arbitrates N_REQ AXI-stream frame sources round-robin, one whole frame at a time, onto the single RAM write port.
- Per frame: writes the data words first, then the length header word in the slot reserved ahead of them, then publishes the new write pointer to the reader.
- Blocks a new grant unless the buffer can hold a worst-case frame.

Parameters:
N_REQ, 4, number of stream requesters
DATA_W, 512, buffer word / stream data width
EN_W, DATA_W/8, RAM byte-write-enable width
ADDR_W, 10, buffer address and pointer width (depth 2^ADDR_W words)
MAX_FRAME_W, 64, maximum data words per frame (header excluded); must be < 2^ADDR_W - 1

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
s_tvalid_i  in  N_REQ  per-requester valid
s_tready_o  out  N_REQ  per-requester ready
s_tdata_i  in  N_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
s_tlast_i  in  N_REQ  per-requester end of frame
rd_ptr_i  in  ADDR_W  reader's consumed pointer
wr_ptr_o  out  ADDR_W  published write pointer (next header slot)
en_a_o  out  1  RAM write enable
wren_a_o  out  EN_W  byte enables (all ones when en_a_o=1, else 0)
wraddr_a_o  out  ADDR_W  RAM write address
wrdata_a_o  out  DATA_W  RAM write data
grant_o  out  N_REQ  one-hot current owner (0 when idle)
busy_o  out  1  high in every state except IDLE
err_oversize_o  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset (synchronous, resetn=0):
  - state=IDLE; wr_ptr_o=0; grant_o=0; rr_ptr=0.
  - en_a_o=0, wren_a_o=0, wraddr_a_o=0, wrdata_a_o=0.
  - s_tready_o=0, busy_o=0, err_oversize_o=0.
  - Reset mid-frame discards the partial frame; the header is never written and wr_ptr_o is not advanced.
- Space check: used = (wr_ptr_o - rd_ptr_i) mod 2^ADDR_W; free = 2^ADDR_W - 1 - used. eligible = free >= MAX_FRAME_W + 1.
- All RAM and pointer outputs are registered. s_tready_o is decoded from the registered state and grant only (no input-to-output combinational path).
- IDLE:
  - If eligible and any s_tvalid_i is set, grant the first valid requester searching upward from rr_ptr, wrapping.
  - On grant: grant_o=one-hot; hdr_addr=wr_ptr_o; data_addr=wr_ptr_o+1; len=0; go to DATA.
  - One-cycle arbitration latency: s_tready is never asserted in IDLE.
- DATA:
  - s_tready_o[g]=1 for the granted requester only.
  - On each beat (valid & ready): write en=1, addr=data_addr, data=s_tdata of g; then data_addr++ (wraps mod 2^ADDR_W) and len++.
  - If tlast on the beat, go to HDR.
  - Else if len+1 == MAX_FRAME_W, pulse err_oversize_o and go to DRAIN.
  - No beat means no write; the block stalls indefinitely.
- DRAIN:
  - s_tready_o[g]=1; beats are discarded with no RAM write.
  - On a tlast beat, go to HDR. len stays at MAX_FRAME_W.
- HDR: write en=1, addr=hdr_addr, data=len zero-extended to DATA_W; go to PUB.
- PUB:
  - wr_ptr_o <= hdr_addr + len + 1 (mod 2^ADDR_W).
  - rr_ptr <= (g+1) mod N_REQ; grant_o <= 0; go to IDLE.
  - The new wr_ptr_o is visible 2 cycles after the header write cycle, so the reader never sees a pointer ahead of a committed header.
- Buffer layout: header then len data words, contiguous with wrap. This matches the reader, which reads header, then len words, advancing its pointer per word.
- Minimum frame is 1 data word. A single-beat frame with tlast goes DATA to HDR.
- Simultaneous requests are resolved by round-robin only. Requesters that are not granted see s_tready=0 and must hold their data.
- A transfer in progress is never pre-empted. rd_ptr_i changes mid-frame are ignored; space was reserved at grant.

Test Plan:
- Req0 sends 3 words D0..D2 (tlast on D2), wr_ptr=0 -> RAM writes addr1=D0, addr2=D1, addr3=D2, then addr0=3; wr_ptr_o becomes 4; grant_o=0001 during the frame.
- All 4 requesters valid with 1-word frames, rr_ptr=0 -> grant order 0,1,2,3; requester 0 again only after 3; wr_ptr_o ends at 8.
- rd_ptr_i=0, wr_ptr_o=960 (free=63 < 65), req1 valid -> no grant, s_tready=0; raise rd_ptr_i to 2 (free=65) -> grant on the next IDLE cycle.
- Req2 sends 70 words -> first 64 written, err_oversize_o pulses once, 6 words drained with ready held high, header=64, wr_ptr_o advances by 65.
- wr_ptr_o=1022, rd_ptr_i=1000, 4-word frame -> header at 1022, data at 1023,0,1,2; wr_ptr_o=3.
- resetn low for one cycle after 2 of 5 beats -> all outputs at reset values, wr_ptr_o=0, no header written; the next frame is written from address 0.
